// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths and select encodings for the 1-to-2 registered demux
package demux_pkg;

    localparam int DEF_W     = 1;
    localparam int DEF_CNT_W = 8;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

    function automatic logic sel_match(input logic sel, input logic ch);
        return sel == ch;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slice with valid/ready and wrap-around dispatch counter
module demux_slot
    import demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             ready,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             can_load
);

    // A full slot can take a new word in the same cycle its consumer drains it.
    assign can_load = ~valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
            count <= '0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
            count <= count + 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux2_reg.sv
// rtl/demux2_reg.sv - registered 1-to-2 demultiplexer with per-channel valid/ready handshake
module demux2_reg
    import demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     i,
    input  logic             j,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     o0,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic [W-1:0]     o1,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    logic can_load0;
    logic can_load1;
    logic accept;
    logic load0;
    logic load1;

    // Only the selected channel gates in_ready, so a stalled channel never blocks the other.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = sel_match(j, SEL_CH1) ? can_load1 : can_load0;
        end
    end

    assign accept = in_valid & in_ready;
    assign load0  = accept & sel_match(j, SEL_CH0);
    assign load1  = accept & sel_match(j, SEL_CH1);

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load0),
        .din      (i),
        .ready    (o0_ready),
        .dout     (o0),
        .valid    (o0_valid),
        .count    (count0),
        .can_load (can_load0)
    );

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load1),
        .din      (i),
        .ready    (o1_ready),
        .dout     (o1),
        .valid    (o1_valid),
        .count    (count1),
        .can_load (can_load1)
    );

endmodule

// File: tb/tb_demux2_reg.sv
// tb/tb_demux2_reg.sv - self-checking bench for demux2_reg against a channel-level reference model
module tb_demux2_reg;

    logic       clk;
    logic       rst;
    logic [0:0] i;
    logic       j;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] o0;
    logic       o0_valid;
    logic       o0_ready;
    logic [0:0] o1;
    logic       o1_valid;
    logic       o1_ready;
    logic [7:0] count0;
    logic [7:0] count1;

    logic       w_in_ready;
    logic [0:0] w_o0;
    logic       w_o0_valid;
    logic [0:0] w_o1;
    logic       w_o1_valid;
    logic [1:0] w_count0;
    logic [1:0] w_count1;

    int checks;
    int failures;

    logic m_d [2];
    logic m_v [2];
    int   m_c [2];
    logic obs_ir;
    logic exp_ir;

    demux2_reg #(.W(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i(i), .j(j), .in_valid(in_valid), .in_ready(in_ready),
        .o0(o0), .o0_valid(o0_valid), .o0_ready(o0_ready),
        .o1(o1), .o1_valid(o1_valid), .o1_ready(o1_ready),
        .count0(count0), .count1(count1)
    );

    demux2_reg #(.W(1), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .i(i), .j(j), .in_valid(in_valid), .in_ready(w_in_ready),
        .o0(w_o0), .o0_valid(w_o0_valid), .o0_ready(o0_ready),
        .o1(w_o1), .o1_valid(w_o1_valid), .o1_ready(o1_ready),
        .count0(w_count0), .count1(w_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_d[c] = 1'b0;
            m_v[c] = 1'b0;
            m_c[c] = 0;
        end
    endtask

    // Drive one cycle, capture in_ready before the edge, advance the model, settle after the edge.
    task automatic step(input logic vi, input logic vj, input logic vv, input logic r0, input logic r1);
        logic acc;
        logic rdy [2];
        i = vi; j = vj; in_valid = vv; o0_ready = r0; o1_ready = r1;
        rdy[0] = r0;
        rdy[1] = r1;
        #1;
        obs_ir = in_ready;
        exp_ir = !m_v[vj] || rdy[vj];
        acc = vv && exp_ir;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (acc && (int'(vj) == c)) begin
                m_d[c] = vi;
                m_v[c] = 1'b1;
                m_c[c] = m_c[c] + 1;
            end else if (rdy[c]) begin
                m_v[c] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0; i = 1'b0; j = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; j = 1'b0; i = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b%b expected 00", o0_valid, o1_valid); end
        checks++; if (o0 !== 1'b0 || o1 !== 1'b0) begin failures++; $display("FAIL reset_data: got %b%b expected 00", o0, o1); end
        checks++; if (count0 !== 8'd0 || count1 !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d/%0d expected 0/0", count0, count1); end
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (count0 !== 8'd3) begin failures++; $display("FAIL prereset_count0: got %0d expected 3", count0); end
        checks++; if (o0_valid !== 1'b1 || o1_valid !== 1'b1) begin failures++; $display("FAIL prereset_full: got %b%b expected 11", o0_valid, o1_valid); end
        in_valid = 1'b1; j = 1'b1; o0_ready = 1'b0; o1_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b%b expected 00", o0_valid, o1_valid); end
        checks++; if (count0 !== 8'd0 || count1 !== 8'd0) begin failures++; $display("FAIL midreset_count: got %0d/%0d expected 0/0", count0, count1); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
        do_reset();
    endtask

    task automatic test_routing();
        logic vj;
        logic vi;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            vj = (k >= 4);
            vi = k[0];
            step(vi, vj, 1'b1, 1'b1, 1'b1);
            checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL route_in_ready[%0d]: got %b expected 1", k, obs_ir); end
            if (vj) begin
                checks++; if (o1 !== vi || o1_valid !== 1'b1) begin failures++; $display("FAIL route_o1[%0d]: got %b/%b expected %b/1", k, o1, o1_valid, vi); end
            end else begin
                checks++; if (o0 !== vi || o0_valid !== 1'b1) begin failures++; $display("FAIL route_o0[%0d]: got %b/%b expected %b/1", k, o0, o0_valid, vi); end
            end
        end
        checks++; if (count0 !== 8'd4 || count1 !== 8'd4) begin failures++; $display("FAIL route_counts: got %0d/%0d expected 4/4", count0, count1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready_ch0: got %b expected 0", obs_ir); end
        checks++; if (o0 !== 1'b1 || o0_valid !== 1'b1 || count0 !== 8'd1) begin failures++; $display("FAIL bp_o0_hold: got %b/%b/%0d expected 1/1/1", o0, o0_valid, count0); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL bp_in_ready_ch1: got %b expected 1", obs_ir); end
        checks++; if (o1 !== 1'b1 || o1_valid !== 1'b1 || count1 !== 8'd1) begin failures++; $display("FAIL bp_o1: got %b/%b/%0d expected 1/1/1", o1, o1_valid, count1); end
    endtask

    task automatic test_drain_refill();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL refill_in_ready: got %b expected 1", obs_ir); end
        checks++; if (o0 !== 1'b1 || o0_valid !== 1'b1 || count0 !== 8'd2) begin failures++; $display("FAIL refill_o0: got %b/%b/%0d expected 1/1/2", o0, o0_valid, count0); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] expect_seq [5];
        expect_seq[0] = 2'd1; expect_seq[1] = 2'd2; expect_seq[2] = 2'd3;
        expect_seq[3] = 2'd0; expect_seq[4] = 2'd1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'($urandom_range(1)), 1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (w_count1 !== expect_seq[k]) begin failures++; $display("FAIL wrap_count1[%0d]: got %0d expected %0d", k, w_count1, expect_seq[k]); end
        end
        checks++; if (w_count0 !== 2'd0) begin failures++; $display("FAIL wrap_count0: got %0d expected 0", w_count0); end
    endtask

    task automatic test_dual_drain();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin failures++; $display("FAIL dual_valid: got %b%b expected 00", o0_valid, o1_valid); end
        checks++; if (count0 !== 8'd1 || count1 !== 8'd1) begin failures++; $display("FAIL dual_count: got %0d/%0d expected 1/1", count0, count1); end
        checks++; if (o0 !== 1'b1 || o1 !== 1'b0) begin failures++; $display("FAIL dual_data_kept: got %b%b expected 10", o0, o1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) != 0),
                 ($urandom_range(2) != 0), ($urandom_range(2) != 0));
            checks++; if (obs_ir !== exp_ir) begin failures++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", k, obs_ir, exp_ir); end
            checks++; if (o0_valid !== m_v[0] || o1_valid !== m_v[1]) begin failures++; $display("FAIL rand_valid[%0d]: got %b%b expected %b%b", k, o0_valid, o1_valid, m_v[0], m_v[1]); end
            checks++; if (o0 !== m_d[0] || o1 !== m_d[1]) begin failures++; $display("FAIL rand_data[%0d]: got %b%b expected %b%b", k, o0, o1, m_d[0], m_d[1]); end
            checks++; if (count0 !== 8'(m_c[0] % 256) || count1 !== 8'(m_c[1] % 256)) begin failures++; $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d/%0d", k, count0, count1, m_c[0] % 256, m_c[1] % 256); end
            checks++; if (w_count0 !== 2'(m_c[0] % 4) || w_count1 !== 2'(m_c[1] % 4)) begin failures++; $display("FAIL rand_wcount[%0d]: got %0d/%0d expected %0d/%0d", k, w_count0, w_count1, m_c[0] % 4, m_c[1] % 4); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; i = 1'b0; j = 1'b0; in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
        obs_ir = 1'b0; exp_ir = 1'b0;
        model_clear();
        test_reset();
        test_routing();
        test_backpressure();
        test_drain_refill();
        test_counter_wrap();
        test_dual_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
